// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package boot_pkg;

  localparam int BYTES_PER_WORD         = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

  // Width of a counter that must be able to hold the value `cycles`.
  function automatic int timeout_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam logic [2:0] ST_LEN  = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_CHK  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  typedef enum logic [2:0] {
    LEN  = ST_LEN,
    DATA = ST_DATA,
    CHK  = ST_CHK,
    DONE = ST_DONE,
    ERR  = ST_ERR
  } boot_state_e;

endpackage

// File: rtl/boot_word_assembler.sv
// Shifts accepted bytes into a little-endian 32-bit word.
// Latency: word_vld pulses one cycle after the 4th byte of a word is accepted.
// Backpressure: none; it takes a byte whenever byte_vld is high.
// Ports: byte_vld/byte_dat = accepted byte; emit = raise word_vld for this word;
//   clr = synchronous clear; word_dat = assembled word; word_next = word including
//   the byte offered this cycle; word_last = this byte completes a word.
module boot_word_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  input  logic        emit,
  output logic [31:0] word_dat,
  output logic [31:0] word_next,
  output logic [1:0]  byte_idx,
  output logic        word_last,
  output logic        word_vld
);

  // New bytes enter at the top, so after four bytes the first one sits in [7:0].
  assign word_next = {byte_dat, word_dat[31:8]};
  assign word_last = byte_vld && (byte_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word_dat <= '0;
      byte_idx <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= word_last && emit;
      if (byte_vld) begin
        word_dat <= word_next;
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Loads a length-prefixed byte image into RAM port B, holding the CPU in reset until done.
// Latency: each word is written the cycle after its 4th byte; status follows the frame end by one cycle.
// Backpressure: rx_ready drops outside LEN/DATA/CHK and during the write of the final word.
// Ports: rx_valid/rx_data/rx_ready = byte stream; mem_* = write-only RAM port B;
//   cpu_hold/done/err = status; rearm = restart from DONE/ERR; word_cnt = words written.
// Optional: define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int BASE_WORD      = 0,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rearm,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_wstrb,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   word_cnt
);

  localparam int                  TO_W      = timeout_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [32:0]         MAX_WORDS = (33'd1 << ADDR_WIDTH) - 33'(BASE_WORD);
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(BASE_WORD);
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e FRAME_END = CHK;
`else
  localparam boot_state_e FRAME_END = DONE;
`endif

  boot_state_e         state;
  logic [ADDR_WIDTH:0] n_words;
  logic [ADDR_WIDTH:0] cnt_inc;
  logic [TO_W-1:0]     to_cnt;
  logic [31:0]         word_dat;
  logic [31:0]         word_next;
  logic [1:0]          byte_idx;
  logic                word_last;
  logic                wr_pend;
  logic                final_wr;
  logic                accept;
  logic                rearm_hit;
  logic                to_run;
  logic                to_hit;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  assign rearm_hit = rearm && (state == DONE || state == ERR);
  assign cnt_inc   = word_cnt + 1'b1;
  assign final_wr  = wr_pend && (cnt_inc == n_words);
  // Hold off the byte after the last payload byte for the one cycle in which the
  // final word is written, so it is taken by the next state, not by DATA.
  assign rx_ready  = (state == LEN || state == DATA || state == CHK) && !final_wr;
  assign accept    = rx_valid && rx_ready;
  // The idle timer only runs once a frame has actually started.
  assign to_run    = (state == LEN && byte_idx != 2'd0) || state == DATA || state == CHK;
  assign to_hit    = to_run && !accept && (to_cnt == TO_LAST);

  boot_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (rearm_hit),
    .byte_vld  (accept),
    .byte_dat  (rx_data),
    .emit      (state == DATA),
    .word_dat  (word_dat),
    .word_next (word_next),
    .byte_idx  (byte_idx),
    .word_last (word_last),
    .word_vld  (wr_pend)
  );

  // Address and data are forced to zero outside the write cycle.
  assign mem_en    = wr_pend;
  assign mem_we    = wr_pend;
  assign mem_wstrb = wr_pend ? 4'hF : 4'h0;
  assign mem_addr  = wr_pend ? (BASE_ADDR + word_cnt[ADDR_WIDTH-1:0]) : '0;
  assign mem_din   = wr_pend ? word_dat : '0;

  assign cpu_hold  = (state != DONE);
  assign done      = (state == DONE);
  assign err       = (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LEN;
      n_words  <= '0;
      word_cnt <= '0;
      to_cnt   <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      if (accept || !to_run)
        to_cnt <= '0;
      else if (!to_hit)
        to_cnt <= to_cnt + 1'b1;

      case (state)
        LEN: begin
          if (accept && word_last) begin
            if (word_next == 32'd0)
              state <= FRAME_END;
            else if ({1'b0, word_next} > MAX_WORDS)
              state <= ERR;
            else begin
              n_words <= word_next[ADDR_WIDTH:0];
              state   <= DATA;
            end
          end else if (to_hit) begin
            state <= ERR;
          end
        end
        DATA: begin
          if (to_hit)
            state <= ERR;
          // A completed write wins over a simultaneous timeout: the word is in RAM.
          if (wr_pend) begin
            word_cnt <= cnt_inc;
            if (final_wr)
              state <= FRAME_END;
          end
`ifdef BOOT_CHECKSUM_EN
          if (accept)
            csum <= csum ^ rx_data;
`endif
        end
`ifdef BOOT_CHECKSUM_EN
        CHK: begin
          if (accept)
            state <= (rx_data == csum) ? DONE : ERR;
          else if (to_hit)
            state <= ERR;
        end
`endif
        DONE, ERR: begin
          if (rearm) begin
            state    <= LEN;
            word_cnt <= '0;
            to_cnt   <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        default: state <= LEN;
      endcase
    end
  end

endmodule
